button_conditioner: RTL

//   Conditions one raw mechanical push-button (roll button) for the 100 MHz core.
//   2-FF synchronizer, debounce FSM, single-cycle press/release pulses, long-press hold flag, auto-repeat.

---
 rtl/button_conditioner_pkg.sv | 27 ++
 rtl/button_conditioner_sync_2ff.sv | 27 ++
 rtl/button_conditioner.sv | 136 +++++++++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the push-button conditioning path.
// Timing defaults assume the 100 MHz core clock.
package button_conditioner_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 0.5 s
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;  // 100 ms

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_HOLD         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_e;

  // One spare bit above the largest terminal count keeps the counter from ever wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Generic two-stage synchronizer for asynchronous level inputs.
// Both stages clear to 0 on synchronous reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Roll-button conditioner: synchronizer, debounce FSM, press/release pulses,
// long-press hold flag and auto-repeat, all outputs registered.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_raw,
  output logic   btn_level,
  output logic   press_pulse,
  output logic   release_pulse,
  output logic   hold,
  output logic   repeat_pulse,
  output state_e dbg_state
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_END   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      DEBOUNCE_CYCLES >= HOLD_CYCLES) begin : g_bad_params
    $error("button_conditioner: timing parameters out of range");
  end

  logic             btn_sync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             hold_q;
  logic             repeat_q;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_sync)
  );

  // A low sample in PRESSED/HOLD always wins over the hold/repeat terminal count,
  // so repeat_pulse is only ever seen while still in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (btn_sync) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!btn_sync) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_END) begin
            state_q <= ST_PRESSED;
            press_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!btn_sync) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end else if (cnt_q == HOLD_END) begin
            state_q <= ST_HOLD;
            hold_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (!btn_sync) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end else if (cnt_q == REP_END) begin
            repeat_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          // hold_q remembers whether the dip started from HOLD or PRESSED.
          if (btn_sync) begin
            state_q <= hold_q ? ST_HOLD : ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_END) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            level_q   <= 1'b0;
            hold_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold          = hold_q;
  assign repeat_pulse  = repeat_q;
  assign dbg_state     = state_q;

endmodule
